// File: rtl/arbiter_pkg.sv
// Shared definitions for the two-host arbiter: ack codes, FSM states and
// the default slave timeout.
package arbiter_pkg;

    // Ack code returned to the winning host for exactly one cycle.
    typedef enum logic [1:0] {
        ACK_NONE = 2'b00,
        ACK_WR   = 2'b01,
        ACK_RD   = 2'b10,
        ACK_ERR  = 2'b11
    } ack_e;

    // Sequencer states: wait for a request, wait for the slave, answer the host.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Cycles spent waiting for s_ready before the host gets an error ack.
    localparam int DEFAULT_TIMEOUT = 15;

    // Width of the slave-wait counter; TIMEOUT must fit in it.
    localparam int CNT_W = 8;

    // Success code for a completed slave access, chosen by its direction.
    function automatic ack_e completionAck(input logic isRead);
        return isRead ? ACK_RD : ACK_WR;
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Two-way round-robin picker. A lone requester always wins; when both hosts
// request, the pointer names the host that has priority. The pointer itself
// is owned by the caller so it can advance only when a grant completes.
module arbiter_rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] win_o
);

    // Resolve the request pair into a one-hot winner (00 when nobody asks).
    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = ptr_i ? 2'b10 : 2'b01;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/arbiter_host_mux.sv
// Shares one slave port between two host ports. One transaction at a time is
// granted with round-robin fairness, registered onto the slave port, and
// answered with data plus a coded ack to the winning host only.
module arbiter_host_mux
    import arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] h0_addr,
    input  logic [3:0]        h0_be,
    input  logic              h0_wr,
    input  logic              h0_rd,
    input  logic [DATA_W-1:0] h0_dwr,
    output logic [DATA_W-1:0] h0_drd,
    output logic [1:0]        h0_ack,

    input  logic [ADDR_W-1:0] h1_addr,
    input  logic [3:0]        h1_be,
    input  logic              h1_wr,
    input  logic              h1_rd,
    input  logic [DATA_W-1:0] h1_dwr,
    output logic [DATA_W-1:0] h1_drd,
    output logic [1:0]        h1_ack,

    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_be,
    output logic [DATA_W-1:0] s_dwr,
    output logic              s_wr,
    output logic              s_rd,
    input  logic [DATA_W-1:0] s_drd,
    input  logic              s_ready,

    output logic [1:0]        grant
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Registered state
    state_e              state_q;
    logic                ptr_q;
    logic                winner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          grant_q;
    logic [ADDR_W-1:0]   sAddr_q;
    logic [3:0]          sBe_q;
    logic [DATA_W-1:0]   sDwr_q;
    logic                sWr_q;
    logic                sRd_q;
    ack_e                h0Ack_q;
    ack_e                h1Ack_q;
    logic [DATA_W-1:0]   h0Drd_q;
    logic [DATA_W-1:0]   h1Drd_q;

    // Next-state values for the slave request registers and counter
    logic [1:0]          req;
    logic [1:0]          win;
    logic                winIdx;
    logic [ADDR_W-1:0]   sAddr_d;
    logic [3:0]          sBe_d;
    logic [DATA_W-1:0]   sDwr_d;
    logic                sWr_d;
    logic                sRd_d;
    logic                illegal_d;
    logic [CNT_W-1:0]    cnt_d;

    assign req    = {h1_wr | h1_rd, h0_wr | h0_rd};
    assign winIdx = win[1];

    arbiter_rr_pick u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win)
    );

    // Steer the winning host's request fields toward the slave registers.
    // A host asserting both wr and rd is flagged so it gets an error ack
    // instead of touching the slave.
    always_comb begin
        sAddr_d   = h0_addr;
        sBe_d     = h0_be;
        sDwr_d    = h0_dwr;
        sWr_d     = h0_wr;
        sRd_d     = h0_rd;
        if (winIdx) begin
            sAddr_d = h1_addr;
            sBe_d   = h1_be;
            sDwr_d  = h1_dwr;
            sWr_d   = h1_wr;
            sRd_d   = h1_rd;
        end
        illegal_d = sWr_d & sRd_d;
    end

    // The wait counter saturates so a very large TIMEOUT can never wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Arbitration sequencer: grant in IDLE, wait for slave in BUSY, answer
    // the winner for one cycle in DONE and hand priority to the other host.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            winner_q <= 1'b0;
            cnt_q    <= '0;
            grant_q  <= 2'b00;
            sAddr_q  <= '0;
            sBe_q    <= '0;
            sDwr_q   <= '0;
            sWr_q    <= 1'b0;
            sRd_q    <= 1'b0;
            h0Ack_q  <= ACK_NONE;
            h1Ack_q  <= ACK_NONE;
            h0Drd_q  <= '0;
            h1Drd_q  <= '0;
        end else begin
            h0Ack_q <= ACK_NONE;
            h1Ack_q <= ACK_NONE;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        winner_q <= winIdx;
                        if (illegal_d) begin
                            state_q <= DONE;
                            if (winIdx) begin
                                h1Ack_q <= ACK_ERR;
                            end else begin
                                h0Ack_q <= ACK_ERR;
                            end
                        end else begin
                            sAddr_q <= sAddr_d;
                            sBe_q   <= sBe_d;
                            sDwr_q  <= sDwr_d;
                            sWr_q   <= sWr_d;
                            sRd_q   <= sRd_d;
                            grant_q <= win;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        sWr_q   <= 1'b0;
                        sRd_q   <= 1'b0;
                        grant_q <= 2'b00;
                        state_q <= DONE;
                        if (winner_q) begin
                            h1Ack_q <= completionAck(sRd_q);
                            if (sRd_q) begin
                                h1Drd_q <= s_drd;
                            end
                        end else begin
                            h0Ack_q <= completionAck(sRd_q);
                            if (sRd_q) begin
                                h0Drd_q <= s_drd;
                            end
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        sWr_q   <= 1'b0;
                        sRd_q   <= 1'b0;
                        grant_q <= 2'b00;
                        state_q <= DONE;
                        if (winner_q) begin
                            h1Ack_q <= ACK_ERR;
                        end else begin
                            h0Ack_q <= ACK_ERR;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    ptr_q   <= ~winner_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_addr = sAddr_q;
    assign s_be   = sBe_q;
    assign s_dwr  = sDwr_q;
    assign s_wr   = sWr_q;
    assign s_rd   = sRd_q;
    assign grant  = grant_q;
    assign h0_ack = h0Ack_q;
    assign h1_ack = h1Ack_q;
    assign h0_drd = h0Drd_q;
    assign h1_drd = h1Drd_q;

endmodule
